mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 17 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i types: memory arbiter FSM state encoding and port-owner enum.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t SERVE_I = 2'd1;
    localparam arb_state_t SERVE_D = 2'd2;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port; ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority.
// Latency: command one cycle after request in IDLE, resp in the pmem_resp cycle, one IDLE cycle between transactions.
// Backpressure: requests are held until their resp pulse; pmem command is held until pmem_resp.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mbe,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    arb_state_t  state;
    logic        lat_read;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_mbe;

    logic        i_req;
    logic        d_req;
    logic        grant_d;

    assign i_req = if_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t last_owner;

    // Only contested grants move the owner, so an uncontested fetch never steals the next turn.
    always_comb begin
        grant_d = d_req & (~i_req | (last_owner == OWNER_I));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_I;
        end else if (state == IDLE && i_req && d_req) begin
            last_owner <= grant_d ? OWNER_D : OWNER_I;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mbe   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state     <= grant_d ? SERVE_D : SERVE_I;
                        lat_addr  <= grant_d ? d_addr : if_addr;
                        // A simultaneous read+write from the data port is a store.
                        lat_write <= grant_d & d_write;
                        lat_read  <= grant_d ? (d_read & ~d_write) : 1'b1;
                        lat_wdata <= grant_d ? d_wdata : '0;
                        lat_mbe   <= grant_d ? d_mbe : '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state     <= IDLE;
                        lat_read  <= 1'b0;
                        lat_write <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read  = lat_read;
    assign pmem_write = lat_write;
    assign pmem_addr  = lat_addr;
    assign pmem_wdata = lat_wdata;
    assign pmem_mbe   = lat_mbe;

    // Completion and read data are gated by state, so a stray pmem_resp in IDLE is invisible.
    assign if_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp   = (state == SERVE_D) & pmem_resp;
    assign if_rdata = (state == SERVE_I) ? pmem_rdata : '0;
    assign d_rdata  = (state == SERVE_D) ? pmem_rdata : '0;

endmodule
